ip_yuv_422_pack: RTL and testbench

Sits directly downstream of the YUV444-to-422 converter. It consumes the 16-bit 422 pixel stream with vstr/vend/hstr/hend/dvld framing and packs two consecutive pixels into one 32-bit word. Packed words pass through a small FIFO to a valid/ready output port that feeds the frame-buffer write DMA. The input has no backpressure, so FIFO overflow is detected and flagged.

---
 rtl/ip_yuv_422_pack_if.sv | 19 +
 rtl/ip_yuv_422_pack.sv | 67 ++++++
 tb/tb_ip_yuv_422_pack.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ip_yuv_422_pack_if.sv
// ip_yuv_422_pack_if: 422 pixel input with framing pulses, plus the packed valid/ready output port.
interface ip_yuv_422_pack_if #(parameter int FIFO_AW = 3);
  logic i_vstr, i_vend, i_hstr, i_hend, i_dvld;
  logic [15:0] i_422_data;
  logic i_pk_ready;
  logic o_pk_valid;
  logic [31:0] o_pk_data;
  logic o_pk_sof, o_pk_eol, o_pk_eof;
  logic [FIFO_AW:0] o_fifo_lvl;
  logic o_pk_ovf;
  modport master (
    output i_vstr, i_vend, i_hstr, i_hend, i_dvld, i_422_data, i_pk_ready,
    input  o_pk_valid, o_pk_data, o_pk_sof, o_pk_eol, o_pk_eof, o_fifo_lvl, o_pk_ovf
  );
  modport slave (
    input  i_vstr, i_vend, i_hstr, i_hend, i_dvld, i_422_data, i_pk_ready,
    output o_pk_valid, o_pk_data, o_pk_sof, o_pk_eol, o_pk_eof, o_fifo_lvl, o_pk_ovf
  );
endinterface

// File: rtl/ip_yuv_422_pack.sv
// ip_yuv_422_pack: packs pixel pairs of a 422 stream into 32-bit words, FIFO-buffered to a valid/ready port.
module ip_yuv_422_pack #(parameter int FIFO_AW = 3) (
  input logic yuv_422_pack_clk,
  input logic yuv_422_pack_rst_n,
  ip_yuv_422_pack_if.slave pk
);
  localparam int DEPTH = 2**FIFO_AW;
  logic phase_q, phase_d, sync_q, sync_d, ovf_q, ovf_d, vld_q, vld_d;
  logic [15:0] hold_q, hold_d;
  logic [2:0] htag_q, htag_d;
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [34:0] out_q, out_d;
  logic [34:0] mem_q [DEPTH];
  logic take, ph, push, full, empty, pop, wr_en, drop;
  logic [2:0] ctag;
  logic [34:0] push_word;
  // Pixels are only used once a line start has been seen since reset.
  assign take = pk.i_dvld & (pk.i_hstr | sync_q);
  assign ph = phase_q & ~pk.i_hstr;
  assign ctag = {pk.i_vend, pk.i_hend, pk.i_vstr};
  assign push = take & (ph | pk.i_hend);
  assign push_word = ph ? {htag_q | ctag, pk.i_422_data, hold_q} : {ctag, 16'h0000, pk.i_422_data};
  assign full = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign empty = wr_q == rd_q;
  assign pop = ~empty & (~vld_q | pk.i_pk_ready);
  assign wr_en = push & (~full | pop);
  assign drop = push & full & ~pop;
  always_comb begin
    phase_d = take ? ~ph & ~pk.i_hend : phase_q;
    sync_d = sync_q | (pk.i_dvld & pk.i_hstr);
    hold_d = (take & ~ph) ? pk.i_422_data : hold_q;
    htag_d = (take & ~ph) ? ctag : htag_q;
    ovf_d = drop | (ovf_q & ~(pk.i_dvld & pk.i_vstr));
    wr_d = wr_q + (FIFO_AW+1)'(wr_en);
    rd_d = rd_q + (FIFO_AW+1)'(pop);
    vld_d = pop | (vld_q & ~pk.i_pk_ready);
    out_d = pop ? mem_q[rd_q[FIFO_AW-1:0]] : out_q;
  end
  always_ff @(posedge yuv_422_pack_clk)
    if (wr_en) mem_q[wr_q[FIFO_AW-1:0]] <= push_word;
  always_ff @(posedge yuv_422_pack_clk or negedge yuv_422_pack_rst_n)
    if (!yuv_422_pack_rst_n) begin
      phase_q <= 1'b0;
      sync_q <= 1'b0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
      hold_q <= '0;
      htag_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      out_q <= '0;
    end else begin
      phase_q <= phase_d;
      sync_q <= sync_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
      hold_q <= hold_d;
      htag_q <= htag_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      out_q <= out_d;
    end
  assign pk.o_pk_valid = vld_q;
  assign {pk.o_pk_eof, pk.o_pk_eol, pk.o_pk_sof, pk.o_pk_data} = out_q;
  assign pk.o_fifo_lvl = wr_q - rd_q;
  assign pk.o_pk_ovf = ovf_q;
endmodule

// File: tb/tb_ip_yuv_422_pack.sv
// tb_ip_yuv_422_pack: random and directed stimulus against a queue-level pixel-pair/FIFO model.
module tb_ip_yuv_422_pack;
  localparam int AW = 3;
  typedef logic [34:0] w_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ip_yuv_422_pack_if #(.FIFO_AW(AW)) pk ();
  ip_yuv_422_pack #(.FIFO_AW(AW)) dut (.yuv_422_pack_clk(clk), .yuv_422_pack_rst_n(rst_n), .pk(pk));
  w_t fq[$];
  w_t stg = '0;
  w_t log_q[$];
  bit stg_v = 0, m_ovf = 0, m_sync = 0, pend_v = 0;
  logic [15:0] pend_d = '0;
  logic [2:0] pend_t = '0;
  int errors = 0, checks = 0, cyc = 0, fv = -1, rmode = 0;
  task automatic m_reset();
    fq.delete();
    stg_v = 0;
    stg = '0;
    m_ovf = 0;
    m_sync = 0;
    pend_v = 0;
  endtask
  // Pixel pairing on the stream, then an 8-entry queue plus one output slot.
  task automatic m_step();
    bit has_w, pop, full, drop;
    w_t w;
    logic [2:0] t;
    has_w = 0;
    w = '0;
    t = {pk.i_vend, pk.i_hend, pk.i_vstr};
    if (pk.i_dvld) begin
      if (pk.i_hstr) begin pend_v = 0; m_sync = 1; end
      if (m_sync) begin
        if (pend_v) begin w = {pend_t | t, pk.i_422_data, pend_d}; has_w = 1; pend_v = 0; end
        else if (pk.i_hend) begin w = {t, 16'h0000, pk.i_422_data}; has_w = 1; end
        else begin pend_v = 1; pend_d = pk.i_422_data; pend_t = t; end
      end
    end
    full = fq.size() == 2**AW;
    pop = fq.size() != 0 && (!stg_v || pk.i_pk_ready);
    if (stg_v && pk.i_pk_ready) stg_v = 0;
    if (pop) begin stg = fq.pop_front(); stg_v = 1; end
    drop = has_w && full && !pop;
    if (has_w && !drop) fq.push_back(w);
    m_ovf = drop || (m_ovf && !(pk.i_dvld && pk.i_vstr));
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else begin cyc++; m_step(); end
  end
  initial forever begin
    logic [40:0] act, expv;
    @(negedge clk);
    if (rst_n) begin
      act = {pk.o_pk_valid, pk.o_pk_valid ? {pk.o_pk_eof, pk.o_pk_eol, pk.o_pk_sof, pk.o_pk_data} : 35'h0,
             pk.o_fifo_lvl, pk.o_pk_ovf};
      expv = {stg_v, stg_v ? stg : 35'h0, 4'(fq.size()), m_ovf};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle cyc=%0d act=%h exp=%h (valid,eof,eol,sof,data,lvl,ovf)", cyc, act, expv);
      end
      if (pk.o_pk_valid && fv < 0) fv = cyc;
      if (pk.o_pk_valid && pk.i_pk_ready) log_q.push_back({pk.o_pk_eof, pk.o_pk_eol, pk.o_pk_sof, pk.o_pk_data});
    end
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask
  task automatic px(bit v, logic [15:0] d, bit vs, bit ve, bit hs, bit he);
    @(posedge clk);
    #1;
    pk.i_dvld = v;
    pk.i_422_data = d;
    pk.i_vstr = vs;
    pk.i_vend = ve;
    pk.i_hstr = hs;
    pk.i_hend = he;
    pk.i_pk_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : (rmode == 2) ? ~pk.i_pk_ready : 1'($urandom_range(0, 1));
  endtask
  task automatic idle(int n);
    repeat (n) px(0, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  task automatic line(int n, bit fs, bit fe, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      px(1, 16'($urandom), fs && i == 0, fe && i == n - 1, i == 0, i == n - 1);
    end
  endtask
  initial begin
    int lb, p1c, nl;
    logic [15:0] sent [40];
    pk.i_dvld = 0; pk.i_422_data = '0; pk.i_vstr = 0; pk.i_vend = 0;
    pk.i_hstr = 0; pk.i_hend = 0; pk.i_pk_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pk.o_pk_valid, pk.o_pk_data, pk.o_pk_sof, pk.o_pk_eol, pk.o_pk_eof, pk.o_fifo_lvl, pk.o_pk_ovf}, 64'h0);
    rst_n = 1;
    // 4-pixel single-line frame
    rmode = 0;
    lb = log_q.size();
    fv = -1;
    px(1, 16'h1111, 1, 0, 1, 0);
    px(1, 16'h2222, 0, 0, 0, 0);
    p1c = cyc;
    px(1, 16'h3333, 0, 0, 0, 0);
    px(1, 16'h4444, 0, 1, 0, 1);
    idle(6);
    chk("first_valid_latency", 64'(fv - p1c), 64'd2);
    chk("line4_word0", 64'(log_q[lb]), {29'h0, 3'b001, 32'h22221111});
    chk("line4_word1", 64'(log_q[lb + 1]), {29'h0, 3'b110, 32'h44443333});
    // odd-width line then a fresh line starting at phase 0
    lb = log_q.size();
    px(1, 16'hAAAA, 0, 0, 1, 0);
    px(1, 16'hBBBB, 0, 0, 0, 0);
    px(1, 16'hCCCC, 0, 0, 0, 1);
    px(1, 16'h0001, 0, 0, 1, 0);
    px(1, 16'h0002, 0, 0, 0, 1);
    idle(6);
    chk("odd_word0", 64'(log_q[lb]), {29'h0, 3'b000, 32'hBBBBAAAA});
    chk("odd_pad", 64'(log_q[lb + 1]), {29'h0, 3'b010, 32'h0000CCCC});
    chk("next_line", 64'(log_q[lb + 2]), {29'h0, 3'b010, 32'h00020001});
    // stalled output: 40 pixels with ready low overflow the FIFO
    rmode = 1;
    idle(1);
    lb = log_q.size();
    for (int i = 0; i < 40; i++) begin
      sent[i] = 16'($urandom);
      px(1, sent[i], i == 0, 0, i % 8 == 0, i % 8 == 7);
    end
    idle(2);
    chk("stall_lvl", 64'(pk.o_fifo_lvl), 64'd8);
    chk("stall_ovf", 64'(pk.o_pk_ovf), 64'd1);
    chk("stall_head", {31'h0, pk.o_pk_valid, pk.o_pk_data}, {31'h0, 1'b1, sent[1], sent[0]});
    rmode = 0;
    idle(15);
    chk("drain_count", 64'(log_q.size() - lb), 64'd9);
    chk("drain_first", 64'(log_q[lb][31:0]), {32'h0, sent[1], sent[0]});
    chk("drain_ninth", 64'(log_q[lb + 8][31:0]), {32'h0, sent[17], sent[16]});
    chk("ovf_sticky", 64'(pk.o_pk_ovf), 64'd1);
    // new frame clears the sticky overflow
    px(1, 16'h1234, 1, 0, 1, 0);
    chk("ovf_before_sample", 64'(pk.o_pk_ovf), 64'd1);
    px(1, 16'h5678, 0, 0, 0, 1);
    chk("ovf_cleared", 64'(pk.o_pk_ovf), 64'd0);
    idle(4);
    // ready toggling with continuous even-width lines
    rmode = 2;
    for (int l = 0; l < 10; l++) line(2 * $urandom_range(1, 4), l == 0, l == 9, 0);
    chk("toggle_no_ovf", 64'(pk.o_pk_ovf), 64'd0);
    rmode = 0;
    idle(20);
    // random ready, random gaps and line widths
    rmode = 3;
    nl = 30;
    for (int l = 0; l < nl; l++) line($urandom_range(1, 12), l == 0, l == nl - 1, 1);
    rmode = 0;
    idle(20);
    // asynchronous reset mid-line with words queued
    rmode = 1;
    px(1, 16'h0101, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) px(1, 16'(16'h0202 + i), 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("reset_mid_valid", 64'(pk.o_pk_valid), 64'd0);
    chk("reset_mid_lvl", 64'(pk.o_fifo_lvl), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    rmode = 0;
    lb = log_q.size();
    px(1, 16'h0A0A, 0, 0, 0, 0);
    px(1, 16'h0B0B, 0, 0, 0, 0);
    px(1, 16'h0C0C, 0, 0, 0, 1);
    px(1, 16'h5555, 0, 0, 1, 0);
    px(1, 16'h6666, 0, 1, 0, 1);
    idle(6);
    chk("post_reset_count", 64'(log_q.size() - lb), 64'd1);
    chk("post_reset_word", 64'(log_q[lb]), {29'h0, 3'b110, 32'h66665555});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
